reorder_buffer: RTL

//  In-order retirement buffer of the out-of-order core. Allocates a tag per

---
 rtl/reorder_buffer_pkg.sv | 34 +++
 rtl/reorder_buffer_if.sv | 61 ++++++
 rtl/reorder_buffer_query_port.sv | 39 +++
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared sizing constants, the register "none" encoding and the per-entry
// record of the reorder buffer. Imported by the interface, the top and the
// query-port sub-module (and by the register file, which must agree on ROB_W
// and on the meaning of rd 0).
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_W   = 4;
  localparam int DEPTH   = 1 << ROB_W;
  localparam int XLEN    = 32;
  localparam int COUNT_W = ROB_W + 1;
  localparam int RD_W    = 5;

  // Destination register 0 means "no architectural destination".
  localparam logic [RD_W-1:0] REG_NONE = 5'd0;

  typedef struct packed {
    logic            busy;
    logic            ready;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] val;
    logic            is_br;
    logic            mispred;
    logic [XLEN-1:0] target;
  } rob_entry_t;

  // Tag pointers wrap naturally modulo DEPTH.
  function automatic logic [ROB_W-1:0] rob_inc(input logic [ROB_W-1:0] p);
    return p + ROB_W'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every non-clock/reset signal of the reorder buffer.
//   issue_*   : decoder -> ROB allocation request
//   full, issue_pos, update_* : ROB -> decoder / regfile rename port
//   cdb_*     : result broadcast into the ROB
//   q1_*/q2_* : operand forwarding queries (pos in, ready/val out)
//   commit_*, flush, flush_pc : in-order retirement and redirect
// Modports: master = core side driving the ROB, slave = the ROB itself.
// -----------------------------------------------------------------------------
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic             issue_valid;
  logic [RD_W-1:0]  issue_rd;
  logic             issue_is_branch;
  logic             full;
  logic [ROB_W-1:0] issue_pos;
  logic             update_valid;
  logic [ROB_W-1:0] update_rob_pos;
  logic [RD_W-1:0]  update_rd;

  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_pos;
  logic [XLEN-1:0]  cdb_val;
  logic             cdb_mispredict;
  logic [XLEN-1:0]  cdb_target;

  logic [ROB_W-1:0] q1_pos;
  logic [ROB_W-1:0] q2_pos;
  logic             q1_ready;
  logic             q2_ready;
  logic [XLEN-1:0]  q1_val;
  logic [XLEN-1:0]  q2_val;

  logic             commit_valid;
  logic [ROB_W-1:0] commit_rob_pos;
  logic [RD_W-1:0]  commit_rd;
  logic [XLEN-1:0]  commit_val;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;

  modport master (
    output issue_valid, issue_rd, issue_is_branch,
    output cdb_valid, cdb_rob_pos, cdb_val, cdb_mispredict, cdb_target,
    output q1_pos, q2_pos,
    input  full, issue_pos, update_valid, update_rob_pos, update_rd,
    input  q1_ready, q2_ready, q1_val, q2_val,
    input  commit_valid, commit_rob_pos, commit_rd, commit_val, flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_branch,
    input  cdb_valid, cdb_rob_pos, cdb_val, cdb_mispredict, cdb_target,
    input  q1_pos, q2_pos,
    output full, issue_pos, update_valid, update_rob_pos, update_rd,
    output q1_ready, q2_ready, q1_val, q2_val,
    output commit_valid, commit_rob_pos, commit_rd, commit_val, flush, flush_pc
  );

endinterface

// File: rtl/reorder_buffer_query_port.sv
// -----------------------------------------------------------------------------
// rob_query_port
// Combinational operand lookup for one source register tag.
//   i_pos          : tag to look up
//   i_entry_ready  : per-entry ready flags
//   i_entry_val    : per-entry stored values
//   i_cdb_*        : current-cycle broadcast (bypassed ahead of storage)
//   o_ready/o_val  : value available and the value itself
// -----------------------------------------------------------------------------
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_W-1:0]            i_pos,
  input  logic [DEPTH-1:0]            i_entry_ready,
  input  logic [DEPTH-1:0][XLEN-1:0]  i_entry_val,
  input  logic                        i_cdb_valid,
  input  logic [ROB_W-1:0]            i_cdb_pos,
  input  logic [XLEN-1:0]             i_cdb_val,
  output logic                        o_ready,
  output logic [XLEN-1:0]             o_val
);

  logic w_bypass;

  // A broadcast for the same tag wins over the (older) stored value.
  always_comb begin
    w_bypass = i_cdb_valid && (i_cdb_pos == i_pos);
    o_ready  = 1'b0;
    o_val    = '0;
    if (w_bypass) begin
      o_ready = 1'b1;
      o_val   = i_cdb_val;
    end else begin
      o_ready = i_entry_ready[i_pos];
      o_val   = i_entry_val[i_pos];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// 16-entry in-order retirement buffer. Allocates tails to issuing
// instructions, captures CDB results by tag, forwards operands through two
// query ports and retires the head in order; a mispredicted branch at the
// head raises flush and clears the whole buffer.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   i_rdy  : global enable, low holds all state and gates commit/update/flush
//   bus    : reorder_buffer_if.slave (issue, update, CDB, query, commit)
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rdy,
  reorder_buffer_if.slave  bus
);

  rob_entry_t            r_entry [DEPTH];
  logic [ROB_W-1:0]      r_head;
  logic [ROB_W-1:0]      r_tail;
  logic [COUNT_W-1:0]    r_count;

  logic                       w_full;
  logic                       w_commit;
  logic                       w_flush;
  logic                       w_issue;
  logic                       w_cdb_hit;
  rob_entry_t                 w_head_e;
  logic [DEPTH-1:0]           w_ready_vec;
  logic [DEPTH-1:0][XLEN-1:0] w_val_vec;
  logic                       w_q1_ready;
  logic                       w_q2_ready;
  logic [XLEN-1:0]            w_q1_val;
  logic [XLEN-1:0]            w_q2_val;

  // Handshake decisions; full uses the pre-edge count, so a commit in the
  // same cycle does not make room for an issue.
  always_comb begin
    w_head_e  = r_entry[r_head];
    w_full    = (r_count == COUNT_W'(DEPTH));
    w_commit  = i_rdy && w_head_e.busy && w_head_e.ready;
    w_flush   = w_commit && w_head_e.is_br && w_head_e.mispred;
    w_issue   = i_rdy && bus.issue_valid && !w_full && !w_flush;
    w_cdb_hit = i_rdy && bus.cdb_valid && r_entry[bus.cdb_rob_pos].busy;
  end

  // Flatten per-entry ready/value for the query ports.
  always_comb begin
    w_ready_vec = '0;
    w_val_vec   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ready_vec[i] = r_entry[i].ready;
      w_val_vec[i]   = r_entry[i].val;
    end
  end

  // Combinational outputs; data fields are zeroed when their valid is low.
  always_comb begin
    bus.full           = w_full;
    bus.issue_pos      = r_tail;
    bus.update_valid   = w_issue;
    bus.update_rob_pos = r_tail;
    bus.update_rd      = w_issue  ? bus.issue_rd : REG_NONE;
    bus.commit_valid   = w_commit;
    bus.commit_rob_pos = w_commit ? r_head       : '0;
    bus.commit_rd      = w_commit ? w_head_e.rd  : REG_NONE;
    bus.commit_val     = w_commit ? w_head_e.val : '0;
    bus.flush          = w_flush;
    bus.flush_pc       = w_flush  ? w_head_e.target : '0;
    bus.q1_ready       = w_q1_ready;
    bus.q1_val         = w_q1_val;
    bus.q2_ready       = w_q2_ready;
    bus.q2_val         = w_q2_val;
  end

  rob_query_port u_q1 (
    .i_pos         (bus.q1_pos),
    .i_entry_ready (w_ready_vec),
    .i_entry_val   (w_val_vec),
    .i_cdb_valid   (bus.cdb_valid),
    .i_cdb_pos     (bus.cdb_rob_pos),
    .i_cdb_val     (bus.cdb_val),
    .o_ready       (w_q1_ready),
    .o_val         (w_q1_val)
  );

  rob_query_port u_q2 (
    .i_pos         (bus.q2_pos),
    .i_entry_ready (w_ready_vec),
    .i_entry_val   (w_val_vec),
    .i_cdb_valid   (bus.cdb_valid),
    .i_cdb_pos     (bus.cdb_rob_pos),
    .i_cdb_val     (bus.cdb_val),
    .o_ready       (w_q2_ready),
    .o_val         (w_q2_val)
  );

  // Entry table and pointers. Issue only targets a non-busy tail, so it never
  // collides with a CDB write (which requires busy) in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_rdy) begin
      if (w_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_entry[i] <= '0;
        end
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_cdb_hit) begin
          r_entry[bus.cdb_rob_pos].ready   <= 1'b1;
          r_entry[bus.cdb_rob_pos].val     <= bus.cdb_val;
          r_entry[bus.cdb_rob_pos].mispred <= bus.cdb_mispredict;
          r_entry[bus.cdb_rob_pos].target  <= bus.cdb_target;
        end
        if (w_commit) begin
          r_entry[r_head].busy  <= 1'b0;
          r_entry[r_head].ready <= 1'b0;
          r_head                <= rob_inc(r_head);
        end
        if (w_issue) begin
          r_entry[r_tail] <= '{busy: 1'b1, ready: 1'b0, rd: bus.issue_rd,
                               val: '0, is_br: bus.issue_is_branch,
                               mispred: 1'b0, target: '0};
          r_tail          <= rob_inc(r_tail);
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + COUNT_W'(1);
          2'b01:   r_count <= r_count - COUNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
